// File: rtl/xlr8_fdiv_seq.sv
// xlr8_fdiv_seq -- sequential IEEE-754 single-precision divider (XLR8 DIV unit)
//
// Samples dividend/divisor on the one-cycle start strobe, runs a radix-2
// restoring mantissa division and writes a round-to-nearest-even result
// exactly LATENCY (28) edges after the start edge. The result is held until
// the next write, so the port's latency counter can capture it blindly.
//
// Ports:
//   cp2     in   clock
//   ireset  in   asynchronous reset, active-low
//   en      in   start strobe (one cycle, sampled with dataa/datab)
//   dataa   in   dividend, IEEE-754 single
//   datab   in   divisor, IEEE-754 single
//   result  out  quotient, held until overwritten
//   busy    out  high from the edge after en until the result write
//   done    out  one-cycle pulse in the cycle after the result write
//   flags   out  {invalid, divzero, overflow, underflow}, updated with result
//
// Build option:
//   XLR8_FDIV_FLAGS_EN  defined   -> flags register and exception detection built
//                       undefined -> flags tied to 4'h0
//
// State   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for en; result/flags hold their last value
// S_UNPACK| split operands, form exponent, mantissas, classify specials
// S_ITER  | 26 restoring-division steps, one quotient bit per cycle
// S_ROUND | normalise, round, resolve specials; result written on exit

module xlr8_fdiv_seq #(
  parameter int LATENCY = 28
) (
  input  logic        cp2,
  input  logic        ireset,
  input  logic        en,
  input  logic [31:0] dataa,
  input  logic [31:0] datab,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic [3:0]  flags
);

  // The datapath timing is fixed: 1 unpack + 26 iterations + 1 round.
  generate
    if (LATENCY != 28) begin : g_latency_check
      $error("xlr8_fdiv_seq: LATENCY must be 28");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UNPACK = 2'd1,
    S_ITER   = 2'd2,
    S_ROUND  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    SP_NONE = 3'd0,
    SP_NAN  = 3'd1,
    SP_INF  = 3'd2,
    SP_DIVZ = 3'd3,
    SP_ZERO = 3'd4
  } spec_t;

  localparam logic [4:0] ITER_LOAD = 5'd25;

  state_t state, state_nxt;

  logic [31:0]       op_a, op_b;
  logic              sign_q;
  logic signed [9:0] exp_q;
  logic [23:0]       mb_q;
  logic [24:0]       rem_q;
  logic [25:0]       quo_q;
  logic [4:0]        cnt_q;
  spec_t             spec_q;

  logic              write_en;

  // ---------------------------------------------------------------------
  // Next-state logic. A new start always wins, which gives abort/restart
  // for en while busy and back-to-back starts in the done cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   state_nxt = S_IDLE;
      S_UNPACK: state_nxt = S_ITER;
      S_ITER:   if (cnt_q == 5'd0) state_nxt = S_ROUND;
      S_ROUND:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (en) state_nxt = S_UNPACK;
  end

  assign busy     = (state != S_IDLE);
  // An en in the ROUND cycle aborts that operation, so nothing is written.
  assign write_en = (state == S_ROUND) && !en;

  // ---------------------------------------------------------------------
  // Unpack and classification
  // ---------------------------------------------------------------------
  logic [7:0]        ea, eb;
  logic [22:0]       fa, fb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic signed [9:0] exp_unp;
  spec_t             spec_unp;

  always_comb begin
    ea     = op_a[30:23];
    eb     = op_b[30:23];
    fa     = op_a[22:0];
    fb     = op_b[22:0];
    // Exponent field 0 is zero: denormals are flushed.
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    a_inf  = (ea == 8'hFF) && (fa == 23'd0);
    b_inf  = (eb == 8'hFF) && (fb == 23'd0);
    a_nan  = (ea == 8'hFF) && (fa != 23'd0);
    b_nan  = (eb == 8'hFF) && (fb != 23'd0);

    exp_unp = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'sd127;

    spec_unp = SP_NONE;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf))
      spec_unp = SP_NAN;
    else if (a_inf)
      spec_unp = SP_INF;
    else if (b_zero)
      spec_unp = SP_DIVZ;
    else if (a_zero || b_inf)
      spec_unp = SP_ZERO;
  end

  // ---------------------------------------------------------------------
  // One restoring-division step. The remainder stays below 2*mb, so the
  // difference always fits in 24 bits before the shift.
  // ---------------------------------------------------------------------
  logic        q_bit;
  logic [24:0] rem_diff;
  logic [24:0] rem_nxt;

  always_comb begin
    q_bit    = (rem_q >= {1'b0, mb_q});
    rem_diff = q_bit ? (rem_q - {1'b0, mb_q}) : rem_q;
    rem_nxt  = {rem_diff[23:0], 1'b0};
  end

  // ---------------------------------------------------------------------
  // Normalise and round. q[25] is the integer bit; a quotient below 1.0
  // needs one left shift and an exponent decrement.
  // ---------------------------------------------------------------------
  logic [25:0]       q_norm;
  logic signed [9:0] exp_norm;
  logic signed [9:0] exp_fin;
  logic              guard, sticky, rnd_up;
  logic [23:0]       mant_sum;
  logic              ovf, unf;
  logic [31:0]       res_val;

  always_comb begin
    q_norm   = quo_q[25] ? quo_q : {quo_q[24:0], 1'b0};
    exp_norm = quo_q[25] ? exp_q : (exp_q - 10'sd1);
    guard    = q_norm[1];
    sticky   = q_norm[0] | (|rem_q);
    rnd_up   = guard & (sticky | q_norm[2]);
    mant_sum = {1'b0, q_norm[24:2]} + {23'd0, rnd_up};
    // A carry out of the mantissa leaves mant_sum[22:0] at zero and bumps
    // the exponent, i.e. 1.111..1 rounds up to 1.0 * 2.
    exp_fin  = exp_norm + $signed({9'd0, mant_sum[23]});
    ovf      = (exp_fin >= 10'sd255);
    unf      = (exp_fin <= 10'sd0);

    res_val = {sign_q, exp_fin[7:0], mant_sum[22:0]};
    if (ovf)
      res_val = {sign_q, 8'hFF, 23'd0};
    else if (unf)
      res_val = {sign_q, 31'd0};

    case (spec_q)
      SP_NAN:          res_val = 32'h7FC0_0000;
      SP_INF, SP_DIVZ: res_val = {sign_q, 8'hFF, 23'd0};
      SP_ZERO:         res_val = {sign_q, 31'd0};
      default:         ;
    endcase
  end

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      state  <= S_IDLE;
      op_a   <= '0;
      op_b   <= '0;
      sign_q <= 1'b0;
      exp_q  <= '0;
      mb_q   <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      spec_q <= SP_NONE;
      result <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= write_en;

      if (en) begin
        op_a <= dataa;
        op_b <= datab;
      end

      case (state)
        S_UNPACK: begin
          sign_q <= op_a[31] ^ op_b[31];
          exp_q  <= exp_unp;
          mb_q   <= {1'b1, fb};
          rem_q  <= {2'b01, fa};
          quo_q  <= '0;
          cnt_q  <= ITER_LOAD;
          spec_q <= spec_unp;
        end
        S_ITER: begin
          rem_q <= rem_nxt;
          quo_q <= {quo_q[24:0], q_bit};
          if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
        end
        default: ;
      endcase

      if (write_en) result <= res_val;
    end
  end

  // ---------------------------------------------------------------------
  // Exception flags
  // ---------------------------------------------------------------------
`ifdef XLR8_FDIV_FLAGS_EN
  logic [3:0] res_flg;
  logic [3:0] flags_q;

  always_comb begin
    res_flg = {(spec_q == SP_NAN),
               (spec_q == SP_DIVZ),
               (spec_q == SP_NONE) && ovf,
               (spec_q == SP_NONE) && !ovf && unf};
  end

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset)
      flags_q <= '0;
    else if (write_en)
      flags_q <= res_flg;
  end

  assign flags = flags_q;
`else
  assign flags = 4'h0;
`endif

endmodule
